if_stage: RTL and testbench

- Instruction-fetch stage sitting directly upstream of the instruction memory.
- Owns the program counter and drives the byte address into instruction memory.
- Captures the returned big-endian 32-bit word into the IF/ID pipeline register for the decode stage.
- Handles stall, branch/jump redirect with flush, end-of-program halt, and keeps a fetched-instruction counter.

---
 rtl/if_stage.sv | 91 +++++++++
 tb/tb_if_stage.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, addresses imem, loads IF/ID.
// Ports: clk/rst_n, stall, redirect_*, imem_*, ifid_*, halted, fetch_count.
package pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;
endpackage

module if_stage
  import pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 72,
  parameter int unsigned COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [31:0]        imem_addr,
  input  logic [31:0]        imem_instr,
  output logic               ifid_valid,
  output logic [31:0]        ifid_instr,
  output logic [31:0]        ifid_pc,
  output logic [31:0]        ifid_pc_plus4,
  output logic               halted,
  output logic [COUNT_W-1:0] fetch_count
);

  logic [31:0]        pc_q;
  logic [31:0]        pc_d;
  logic [31:0]        pc_inc;
  if_id_t             ifid_q;
  if_id_t             ifid_d;
  logic [COUNT_W-1:0] cnt_q;
  logic [COUNT_W-1:0] cnt_d;

  assign pc_inc    = pc_q + 32'd4;
  assign imem_addr = pc_q;
  assign halted    = (pc_q >= 32'(IMEM_BYTES));

  // Arms overlap (redirect with stall), so order decides.
  always_comb begin
    pc_d   = pc_q;
    ifid_d = ifid_q;
    cnt_d  = cnt_q;
    priority case (1'b1)
      redirect_valid: begin
        pc_d   = {redirect_pc[31:2], 2'b00};
        ifid_d = '0;
      end
      stall: begin
        pc_d = pc_q;
      end
      halted: begin
        ifid_d = '0;
      end
      default: begin
        pc_d            = pc_inc;
        ifid_d.valid    = 1'b1;
        ifid_d.instr    = imem_instr;
        ifid_d.pc       = pc_q;
        ifid_d.pc_plus4 = pc_inc;
        if (!(&cnt_q))
          cnt_d = cnt_q + COUNT_W'(1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      ifid_q <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ifid_valid    = ifid_q.valid;
  assign ifid_instr    = ifid_q.instr;
  assign ifid_pc       = ifid_q.pc;
  assign ifid_pc_plus4 = ifid_q.pc_plus4;
  assign fetch_count   = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: scoreboard of expected
// IF/ID state per cycle plus directed scenario checks.
module tb_if_stage;

  localparam int NB = 72;

  typedef struct packed {
    logic [31:0] addr;
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] p4;
    logic [15:0] cnt;
    logic        h;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic        halted;
  logic [15:0] fetch_count;

  logic        s_redir = 1'b0;
  logic [31:0] s_rpc = '0;
  logic [31:0] s_addr;
  logic [31:0] s_instr;
  logic        s_valid;
  logic [31:0] s_ifinstr;
  logic [31:0] s_ifpc;
  logic [31:0] s_ifp4;
  logic        s_halted;
  logic [2:0]  s_count;

  logic [7:0]  mem [0:NB-1];
  logic [31:0] prog [0:NB/4-1];

  exp_t        sb [$];
  exp_t        m_ifid;
  logic [31:0] m_pc;
  logic [15:0] m_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    int i;
    i = int'(a);
    if (a < 32'(NB))
      return {mem[i], mem[i+1], mem[i+2], mem[i+3]};
    return 32'h0;
  endfunction

  always_comb imem_instr = rom(imem_addr);
  always_comb s_instr = rom(s_addr);

  if_stage #(.IMEM_BYTES(NB), .COUNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4),
    .halted(halted), .fetch_count(fetch_count)
  );

  if_stage #(.IMEM_BYTES(NB), .COUNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .stall(1'b0),
    .redirect_valid(s_redir), .redirect_pc(s_rpc),
    .imem_addr(s_addr), .imem_instr(s_instr),
    .ifid_valid(s_valid), .ifid_instr(s_ifinstr),
    .ifid_pc(s_ifpc), .ifid_pc_plus4(s_ifp4),
    .halted(s_halted), .fetch_count(s_count)
  );

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    s_redir = 1'b0;
    #2;
    rst_n = 1'b1;
    m_pc = 0;
    m_cnt = 0;
    m_ifid = '0;
    sb.delete();
  endtask

  // Advance the model one edge, queue its expectation, then
  // step the DUT and compare against the popped entry.
  task automatic cycle(input logic s, input logic r,
                       input logic [31:0] rpc);
    exp_t e;
    exp_t got;
    if (r) begin
      m_pc = {rpc[31:2], 2'b00};
      m_ifid = '0;
    end else if (s) begin
      m_pc = m_pc;
    end else if (m_pc >= 32'(NB)) begin
      m_ifid = '0;
    end else begin
      m_ifid.v = 1'b1;
      m_ifid.instr = prog[m_pc[31:2]];
      m_ifid.pc = m_pc;
      m_ifid.p4 = m_pc + 4;
      m_pc = m_pc + 4;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
    end
    e = m_ifid;
    e.addr = m_pc;
    e.cnt = m_cnt;
    e.h = (m_pc >= 32'(NB));
    sb.push_back(e);
    stall = s;
    redirect_valid = r;
    redirect_pc = rpc;
    @(posedge clk); #1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    e = sb.pop_front();
    got = {imem_addr, ifid_valid, ifid_instr, ifid_pc,
           ifid_pc_plus4, fetch_count, halted};
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL scoreboard t=%0t got %h exp %h",
               $time, got, e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({imem_addr, ifid_valid, ifid_instr, ifid_pc,
         ifid_pc_plus4, fetch_count, halted} !== '0) begin
      n_fail++;
      $display("FAIL reset_state addr=%h v=%b cnt=%0d h=%b",
               imem_addr, ifid_valid, fetch_count, halted);
    end
  endtask

  task automatic test_straight();
    do_reset();
    n_chk++;
    if (imem_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL first_addr got %h exp 0", imem_addr);
    end
    cycle(0, 0, 0);
    n_chk++;
    if ({ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4,
         imem_addr} !== {1'b1, 32'h01294020, 32'd0, 32'd4,
         32'd4}) begin
      n_fail++;
      $display("FAIL first_fetch v=%b i=%h pc=%h p4=%h a=%h",
               ifid_valid, ifid_instr, ifid_pc,
               ifid_pc_plus4, imem_addr);
    end
    for (int i = 1; i < 7; i++) begin
      cycle(0, 0, 0);
      n_chk++;
      if (fetch_count !== 16'(i + 1)) begin
        n_fail++;
        $display("FAIL count_step got %0d exp %0d",
                 fetch_count, i + 1);
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0);
      n_chk++;
      if ({imem_addr, ifid_pc, ifid_instr, fetch_count} !==
          {32'd28, 32'd24, 32'hAE130008, 16'd7}) begin
        n_fail++;
        $display("FAIL stall_hold a=%h pc=%h i=%h c=%0d",
                 imem_addr, ifid_pc, ifid_instr, fetch_count);
      end
    end
    cycle(0, 0, 0);
    n_chk++;
    if ({ifid_pc, ifid_instr} !== {32'd28, 32'h8DF30002}) begin
      n_fail++;
      $display("FAIL stall_release pc=%h i=%h exp 1c/8df30002",
               ifid_pc, ifid_instr);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
    cycle(0, 1, 32'h2E);
    n_chk++;
    if ({imem_addr, ifid_valid, ifid_instr, fetch_count} !==
        {32'h2C, 1'b0, 32'h0, 16'd4}) begin
      n_fail++;
      $display("FAIL redirect_flush a=%h v=%b i=%h c=%0d",
               imem_addr, ifid_valid, ifid_instr, fetch_count);
    end
    cycle(0, 0, 0);
    n_chk++;
    if ({ifid_pc, ifid_instr} !== {32'h2C, 32'h01AC7020}) begin
      n_fail++;
      $display("FAIL redirect_target pc=%h i=%h",
               ifid_pc, ifid_instr);
    end
    cycle(1, 1, 32'd8);
    n_chk++;
    if ({imem_addr, ifid_valid, ifid_pc} !==
        {32'd8, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL redirect_over_stall a=%h v=%b pc=%h",
               imem_addr, ifid_valid, ifid_pc);
    end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 18; i++) cycle(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({halted, imem_addr, fetch_count} !==
          {1'b1, 32'd72, 16'd18}) begin
        n_fail++;
        $display("FAIL halt_state h=%b a=%0d c=%0d",
                 halted, imem_addr, fetch_count);
      end
      cycle(0, 0, 0);
      n_chk++;
      if (ifid_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_bubble v=%b exp 0", ifid_valid);
      end
    end
    cycle(0, 1, 32'd0);
    n_chk++;
    if (halted !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_exit h=%b exp 0", halted);
    end
    cycle(0, 0, 0);
    n_chk++;
    if ({ifid_valid, ifid_pc, fetch_count} !==
        {1'b1, 32'd0, 16'd19}) begin
      n_fail++;
      $display("FAIL halt_resume v=%b pc=%h c=%0d",
               ifid_valid, ifid_pc, fetch_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 10; i++) cycle(0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({imem_addr, ifid_valid, fetch_count} !==
        {32'd0, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL async_reset a=%h v=%b c=%0d",
               imem_addr, ifid_valid, fetch_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    int fetched;
    do_reset();
    fetched = 0;
    for (int i = 0; i < 14; i++) begin
      s_redir = (i == 5);
      s_rpc = 32'd0;
      @(posedge clk); #1;
      s_redir = 1'b0;
      if (i != 5) fetched++;
      n_chk++;
      if (s_count !== 3'((fetched > 7) ? 7 : fetched)) begin
        n_fail++;
        $display("FAIL saturate i=%0d got %0d exp %0d",
                 i, s_count, (fetched > 7) ? 7 : fetched);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NB / 4; i++)
      prog[i] = 32'h2000_0000 + 32'(i);
    prog[0] = 32'h01294020;
    prog[6] = 32'hAE130008;
    prog[7] = 32'h8DF30002;
    prog[11] = 32'h01AC7020;
    for (int i = 0; i < NB / 4; i++)
      {mem[4*i], mem[4*i+1], mem[4*i+2], mem[4*i+3]} = prog[i];
    test_reset();
    test_straight();
    test_stall();
    test_redirect();
    test_halt();
    test_async_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
